// File: rtl/mem_arbiter.sv
// Two-port (I/D) to one-port memory arbiter with bounded outstanding reads and sticky protocol error.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise the data side has fixed priority.
module mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_imem_addr,
    input  logic        i_imem_ren,
    output logic        o_imem_ready,
    output logic [31:0] o_imem_rdata,
    output logic        o_imem_valid,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_ready,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_err
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       rst_sync_q;
    logic             rst_n_int;
    logic             grant_i, grant_d;
    logic             req_i, req_d;
    logic             full;
    logic             acc_rd, acc_wr;
`ifdef MEM_ARBITER_RR_EN
    logic             last_d_q, last_d_d;
`endif

    // Assert immediately, release two edges after i_rst_n rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`ifdef MEM_ARBITER_RR_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    // Grant, forwarding and next-state logic.
    always_comb begin
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        req_i        = i_imem_ren;
        req_d        = i_dmem_ren | i_dmem_wen;
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
`ifdef MEM_ARBITER_RR_EN
        last_d_d     = last_d_q;
`endif

        if (rst_n_int) begin
            unique case (state_q)
                IDLE: begin
`ifdef MEM_ARBITER_RR_EN
                    if (req_i && req_d) begin
                        grant_d = !last_d_q;
                        grant_i = last_d_q;
                    end else begin
                        grant_d = req_d;
                        grant_i = req_i;
                    end
`else
                    grant_d = req_d;
                    grant_i = req_i && !req_d;
`endif
                end
                OWN_I:   grant_i = 1'b1;
                OWN_D:   grant_d = 1'b1;
                default: ;
            endcase
        end

        full = (state_q != IDLE) && (cnt_q == MAX_CNT);

        o_mem_addr   = grant_d ? i_dmem_addr : (grant_i ? i_imem_addr : '0);
        o_mem_wdata  = grant_d ? i_dmem_wdata : '0;
        o_mem_ren    = !full && (grant_d ? i_dmem_ren : (grant_i && i_imem_ren));
        o_mem_wen    = !full && grant_d && i_dmem_wen;
        o_imem_ready = grant_i && i_mem_ready && !full;
        o_dmem_ready = grant_d && i_mem_ready && !full;

        o_imem_valid = (state_q == OWN_I) && i_mem_valid;
        o_dmem_valid = (state_q == OWN_D) && i_mem_valid;
        o_imem_rdata = (state_q == OWN_I) ? i_mem_rdata : '0;
        o_dmem_rdata = (state_q == OWN_D) ? i_mem_rdata : '0;

        acc_rd = o_mem_ren && i_mem_ready;
        acc_wr = o_mem_wen && i_mem_ready;

        if (state_q == IDLE) begin
            // A response with nothing in flight is a protocol violation; it is dropped.
            if (i_mem_valid) begin
                err_d = 1'b1;
            end
            if (acc_rd) begin
                state_d = grant_d ? OWN_D : OWN_I;
                cnt_d   = CNT_W'(1);
            end
`ifdef MEM_ARBITER_RR_EN
            if (acc_wr) begin
                last_d_d = grant_d;
            end
`endif
        end else begin
            cnt_d = cnt_q + CNT_W'(acc_rd) - CNT_W'(i_mem_valid);
            if (cnt_d == '0) begin
                state_d = IDLE;
`ifdef MEM_ARBITER_RR_EN
                last_d_d = (state_q == OWN_D);
`endif
            end
        end
    end

    assign o_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle plus literal spot checks.
module tb_mem_arbiter;

    localparam int unsigned MAXO = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
    logic        imem_ren, dmem_ren, dmem_wen, mem_ready, mem_valid;
    logic        o_imem_ready, o_imem_valid, o_dmem_ready, o_dmem_valid;
    logic [31:0] o_imem_rdata, o_dmem_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_ren, o_mem_wen, o_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct packed {
        logic        imem_ready;
        logic [31:0] imem_rdata;
        logic        imem_valid;
        logic        dmem_ready;
        logic [31:0] dmem_rdata;
        logic        dmem_valid;
        logic [31:0] mem_addr;
        logic        mem_ren;
        logic        mem_wen;
        logic [31:0] mem_wdata;
        logic        err;
    } outs_t;

    mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_imem_addr  (imem_addr),
        .i_imem_ren   (imem_ren),
        .o_imem_ready (o_imem_ready),
        .o_imem_rdata (o_imem_rdata),
        .o_imem_valid (o_imem_valid),
        .i_dmem_addr  (dmem_addr),
        .i_dmem_ren   (dmem_ren),
        .i_dmem_wen   (dmem_wen),
        .i_dmem_wdata (dmem_wdata),
        .o_dmem_ready (o_dmem_ready),
        .o_dmem_rdata (o_dmem_rdata),
        .o_dmem_valid (o_dmem_valid),
        .o_mem_addr   (o_mem_addr),
        .o_mem_ren    (o_mem_ren),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_ready  (mem_ready),
        .i_mem_rdata  (mem_rdata),
        .i_mem_valid  (mem_valid),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: who owns the port (0 none, 1 I, 2 D), reads in flight, last grant was D, error seen.
    int m_owner    = 0;
    int m_inflight = 0;
    bit m_last_d   = 1'b0;
    bit m_err      = 1'b0;

    function automatic outs_t model_outs(output int win);
        outs_t o;
        bit    ri, rd, full;
        o   = '0;
        win = 0;
        if (!rst_n) return o;
        ri = imem_ren;
        rd = dmem_ren || dmem_wen;
        if (m_owner != 0) win = m_owner;
        else if (ri && rd) begin
`ifdef MEM_ARBITER_RR_EN
            win = m_last_d ? 1 : 2;
`else
            win = 2;
`endif
        end
        else if (rd) win = 2;
        else if (ri) win = 1;
        full = (m_owner != 0) && (m_inflight == int'(MAXO));
        if (win == 1) begin
            o.mem_addr   = imem_addr;
            o.mem_ren    = imem_ren && !full;
            o.imem_ready = mem_ready && !full;
        end else if (win == 2) begin
            o.mem_addr   = dmem_addr;
            o.mem_wdata  = dmem_wdata;
            o.mem_ren    = dmem_ren && !full;
            o.mem_wen    = dmem_wen && !full;
            o.dmem_ready = mem_ready && !full;
        end
        if (m_owner == 1) begin
            o.imem_valid = mem_valid;
            o.imem_rdata = mem_rdata;
        end else if (m_owner == 2) begin
            o.dmem_valid = mem_valid;
            o.dmem_rdata = mem_rdata;
        end
        o.err = m_err;
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        outs_t o;
        int    w, n;
        bit    rd_acc, wr_acc;
        if (!rst_n) begin
            m_owner    <= 0;
            m_inflight <= 0;
            m_last_d   <= 1'b0;
            m_err      <= 1'b0;
        end else begin
            o      = model_outs(w);
            rd_acc = o.mem_ren && mem_ready;
            wr_acc = o.mem_wen && mem_ready;
            if (m_owner == 0) begin
                if (mem_valid) m_err <= 1'b1;
                if (rd_acc) begin
                    m_owner    <= w;
                    m_inflight <= 1;
                end
                if (wr_acc) m_last_d <= (w == 2);
            end else begin
                n = m_inflight + int'(rd_acc) - int'(mem_valid);
                m_inflight <= n;
                if (n == 0) begin
                    m_owner  <= 0;
                    m_last_d <= (m_owner == 2);
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        outs_t e, a;
        int    w;
        e = model_outs(w);
        a = '{o_imem_ready, o_imem_rdata, o_imem_valid, o_dmem_ready, o_dmem_rdata,
              o_dmem_valid, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_err};
        vec_cnt++;
        if (a !== e) begin
            miss_cnt++;
            $display("FAIL cycle_model t=%0t actual=%h expected=%h", $time, a, e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        imem_ren   = 1'b0; imem_addr = '0;
        dmem_ren   = 1'b0; dmem_wen  = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        mem_ready  = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_in();
        #1 rst_n = 1'b0;
        dmem_ren  = 1'b1;
        dmem_addr = 32'h0000_0050;
        mem_ready = 1'b1;
        repeat (3) step();
        #1;
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_dready", 32'(o_dmem_ready), 32'd0);
        chk("rst_mem_ren", 32'(o_mem_ren), 32'd0);
        idle_in();
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // Single I read, latency 2
        imem_ren = 1'b1; imem_addr = 32'h100; mem_ready = 1'b1;
        #1;
        chk("i_rd_ren", 32'(o_mem_ren), 32'd1);
        chk("i_rd_addr", o_mem_addr, 32'h100);
        chk("i_rd_ready", 32'(o_imem_ready), 32'd1);
        step(); imem_ren = 1'b0;
        step(); mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("i_rd_valid", 32'(o_imem_valid), 32'd1);
        chk("i_rd_rdata", o_imem_rdata, 32'h1234_5678);
        chk("i_rd_dvalid", 32'(o_dmem_valid), 32'd0);
        step(); mem_valid = 1'b0;

        // Simultaneous I and D reads after reset: D first, then I
        imem_ren = 1'b1; imem_addr = 32'h104;
        dmem_ren = 1'b1; dmem_addr = 32'h204;
        #1;
        chk("conf_dready", 32'(o_dmem_ready), 32'd1);
        chk("conf_iready", 32'(o_imem_ready), 32'd0);
        chk("conf_addr", o_mem_addr, 32'h204);
        step(); dmem_ren = 1'b0;
        #1 chk("own_d_iready", 32'(o_imem_ready), 32'd0);
        step(); mem_valid = 1'b1; mem_rdata = 32'h0000_D0D0;
        step(); mem_valid = 1'b0;
        #1;
        chk("after_d_iready", 32'(o_imem_ready), 32'd1);
        chk("after_d_addr", o_mem_addr, 32'h104);
        step(); imem_ren = 1'b0;
        step(); mem_valid = 1'b1; mem_rdata = 32'h0000_0104;
        step(); mem_valid = 1'b0;

        // Four-word I line fill while D waits
        imem_ren = 1'b1; imem_addr = 32'h300;
        step(); imem_ren = 1'b0; dmem_ren = 1'b1; dmem_addr = 32'h400;
        #1 chk("fill_dready0", 32'(o_dmem_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            mem_valid = 1'b1; mem_rdata = 32'h3000 + 32'(k);
            imem_ren  = (k < 4); imem_addr = 32'h300 + 32'(4 * k);
            #1;
            chk("fill_dready", 32'(o_dmem_ready), 32'd0);
            chk("fill_ivalid", 32'(o_imem_valid), 32'd1);
            step(); mem_valid = 1'b0; imem_ren = 1'b0;
            #1;
            if (k < 4) chk("fill_gap_dready", 32'(o_dmem_ready), 32'd0);
            else begin
                chk("fill_done_dready", 32'(o_dmem_ready), 32'd1);
                chk("fill_done_addr", o_mem_addr, 32'h400);
            end
        end
        step(); dmem_ren = 1'b0;
        step(); mem_valid = 1'b1; mem_rdata = 32'h0000_0400;
        step(); mem_valid = 1'b0;

        // D write stays in IDLE
        dmem_wen = 1'b1; dmem_addr = 32'h200; dmem_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_wen", 32'(o_mem_wen), 32'd1);
        chk("wr_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        chk("wr_addr", o_mem_addr, 32'h200);
        chk("wr_ren", 32'(o_mem_ren), 32'd0);
        step(); dmem_wen = 1'b0; imem_ren = 1'b1; imem_addr = 32'h108;
        #1;
        chk("wr_no_valid", 32'({o_imem_valid, o_dmem_valid}), 32'd0);
        chk("wr_idle_iready", 32'(o_imem_ready), 32'd1);
        step(); imem_ren = 1'b0;
        step(); mem_valid = 1'b1; mem_rdata = 32'h0000_0108;
        step(); mem_valid = 1'b0;

        // Conflict right after a D write: policy-dependent winner
        dmem_wen = 1'b1; dmem_addr = 32'h208; dmem_wdata = 32'h1;
        step(); dmem_addr = 32'h20C; dmem_wdata = 32'h2; imem_ren = 1'b1; imem_addr = 32'h500;
        #1;
`ifdef MEM_ARBITER_RR_EN
        chk("rr_iready", 32'(o_imem_ready), 32'd1);
        chk("rr_dready", 32'(o_dmem_ready), 32'd0);
`else
        chk("fp_dready", 32'(o_dmem_ready), 32'd1);
        chk("fp_iready", 32'(o_imem_ready), 32'd0);
`endif
        step(); dmem_wen = 1'b0; imem_ren = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        step(); mem_valid = 1'b1; mem_rdata = 32'h0000_0500;
        step(); mem_valid = 1'b0;
`endif

        // Outstanding limit (MAXO=2): third read held until a response
        step(); dmem_ren = 1'b1; dmem_addr = 32'h600;
        step(); dmem_addr = 32'h604;
        step(); dmem_addr = 32'h608;
        #1;
        chk("full_dready", 32'(o_dmem_ready), 32'd0);
        chk("full_ren", 32'(o_mem_ren), 32'd0);
        step();
        #1 chk("full_hold", 32'(o_dmem_ready), 32'd0);
        step(); mem_valid = 1'b1; mem_rdata = 32'h0000_6000;
        #1;
        chk("full_valid_dready", 32'(o_dmem_ready), 32'd0);
        chk("full_dvalid", 32'(o_dmem_valid), 32'd1);
        chk("full_drdata", o_dmem_rdata, 32'h0000_6000);
        step(); mem_valid = 1'b0;
        #1 chk("unfull_dready", 32'(o_dmem_ready), 32'd1);
        step(); dmem_ren = 1'b0;
        step(); mem_valid = 1'b1; mem_rdata = 32'h0000_6004;
        step(); mem_rdata = 32'h0000_6008;
        step(); mem_valid = 1'b0;

        // Stray valid in IDLE, then async reset mid-OWN_D
        mem_valid = 1'b1; mem_rdata = 32'h0000_0BAD;
        #1 chk("stray_novalid", 32'({o_imem_valid, o_dmem_valid}), 32'd0);
        step(); mem_valid = 1'b0;
        #1 chk("stray_err", 32'(o_err), 32'd1);
        step(); dmem_ren = 1'b1; dmem_addr = 32'h700;
        step(); mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        mem_ready = 1'b1; mem_valid = 1'b1;
        #1;
        chk("arst_dready", 32'(o_dmem_ready), 32'd0);
        chk("arst_ren", 32'(o_mem_ren), 32'd0);
        chk("arst_dvalid", 32'(o_dmem_valid), 32'd0);
        chk("arst_err", 32'(o_err), 32'd0);
        step(); idle_in();
        step(); rst_n = 1'b1;
        repeat (4) step();
        mem_valid = 1'b1; mem_rdata = 32'h0000_0777;
        step(); mem_valid = 1'b0;
        #1 chk("late_valid_err", 32'(o_err), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
